// File: rtl/data_memory_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : data_memory_ctrl                                             |
// | Description : Byte-addressed synchronous data memory for the MEM stage.    |
// |               Valid/ready request port, per-byte write strobes, 1- or      |
// |               2-cycle response latency, error response for misaligned or   |
// |               out-of-range addresses, and a post-reset clear sequencer     |
// |               that zeroes every word before requests are accepted.         |
// | Ports       : clk, reset (async, active-high)                              |
// |               req_valid/req_ready/req_write/req_addr/req_wdata/req_be      |
// |               rsp_valid/rsp_rdata/rsp_err  (no response backpressure)      |
// |               busy  - clear sequence in progress                           |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module data_memory_ctrl #(
    parameter int DATA_W         = 32,
    parameter int DEPTH          = 1024,
    parameter int ADDR_W         = 32,
    parameter int RD_LAT         = 1,
    parameter int CLEAR_ON_RESET = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_write,
    input  logic [ADDR_W-1:0]     req_addr,
    input  logic [DATA_W-1:0]     req_wdata,
    input  logic [DATA_W/8-1:0]   req_be,
    output logic                  rsp_valid,
    output logic [DATA_W-1:0]     rsp_rdata,
    output logic                  rsp_err,
    output logic                  busy
);

    localparam int C_NB    = DATA_W / 8;
    localparam int C_LSB   = $clog2(C_NB);
    localparam int C_IDX_W = $clog2(DEPTH);
    localparam int C_TOP   = C_LSB + C_IDX_W;

    localparam logic [0:0] ST_CLEAR = 1'b0;
    localparam logic [0:0] ST_IDLE  = 1'b1;
    localparam logic [0:0] C_RST_STATE = (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_IDLE;
    localparam logic [C_IDX_W-1:0] C_LAST = C_IDX_W'(DEPTH - 1);

    generate
        if ((RD_LAT != 1 && RD_LAT != 2) || (DATA_W < 8) || (DATA_W % 8 != 0) ||
            ((C_NB & (C_NB - 1)) != 0) || (DEPTH < 2) ||
            ((DEPTH & (DEPTH - 1)) != 0) || (C_TOP > ADDR_W)) begin : g_bad_param
            $error("data_memory_ctrl: illegal parameter combination (RD_LAT must be 1 or 2)");
        end
    endgenerate

    // ------------------------------------------------------------------ FSM
    logic [0:0]         state_q, state_d;
    logic [C_IDX_W-1:0] cnt_q, cnt_d;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= C_RST_STATE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // The transition out of CLEAR happens on the same edge that writes the
    // last word, so busy stays high for exactly DEPTH cycles.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (state_q == ST_CLEAR) begin
            cnt_d = cnt_q + C_IDX_W'(1);
            if (cnt_q == C_LAST) begin
                state_d = ST_IDLE;
            end
        end
    end

    // req_ready is also gated by reset so nothing is accepted while reset is
    // held, even when the clear sequence is skipped.
    always_comb begin
        busy      = (state_q == ST_CLEAR);
        req_ready = (state_q == ST_IDLE) && !reset;
    end

    // ------------------------------------------------------- address decode
    logic               w_misalign;
    logic               w_oor;
    logic               w_err;
    logic               w_accept;
    logic [C_IDX_W-1:0] w_idx;

    generate
        if (C_LSB > 0) begin : g_align
            assign w_misalign = |req_addr[C_LSB-1:0];
        end else begin : g_no_align
            assign w_misalign = 1'b0;
        end
        if (C_TOP < ADDR_W) begin : g_range
            assign w_oor = |req_addr[ADDR_W-1:C_TOP];
        end else begin : g_full_range
            assign w_oor = 1'b0;
        end
    endgenerate

    assign w_idx    = req_addr[C_LSB +: C_IDX_W];
    assign w_err    = w_misalign | w_oor;
    assign w_accept = req_valid & req_ready;

    // ---------------------------------------------------------------- array
    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (state_q == ST_CLEAR) begin
            mem[cnt_q] <= '0;
        end else if (w_accept && req_write && !w_err) begin
            for (int i = 0; i < C_NB; i++) begin
                if (req_be[i]) begin
                    mem[w_idx][8*i +: 8] <= req_wdata[8*i +: 8];
                end
            end
        end
    end

    // ------------------------------------------------ response stage 1
    // Data/err only update on an accept so they hold between responses.
    logic              s1_valid_q, s1_valid_d;
    logic              s1_err_q,   s1_err_d;
    logic [DATA_W-1:0] s1_rdata_q, s1_rdata_d;

    always_comb begin
        s1_valid_d = w_accept;
        s1_err_d   = s1_err_q;
        s1_rdata_d = s1_rdata_q;
        if (w_accept) begin
            s1_err_d   = w_err;
            s1_rdata_d = (!req_write && !w_err) ? mem[w_idx] : '0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1_valid_q <= 1'b0;
            s1_err_q   <= 1'b0;
            s1_rdata_q <= '0;
        end else begin
            s1_valid_q <= s1_valid_d;
            s1_err_q   <= s1_err_d;
            s1_rdata_q <= s1_rdata_d;
        end
    end

    // ------------------------------------------------ optional stage 2
    generate
        if (RD_LAT == 2) begin : g_lat2
            logic              s2_valid_q, s2_valid_d;
            logic              s2_err_q,   s2_err_d;
            logic [DATA_W-1:0] s2_rdata_q, s2_rdata_d;

            always_comb begin
                s2_valid_d = s1_valid_q;
                s2_err_d   = s1_valid_q ? s1_err_q   : s2_err_q;
                s2_rdata_d = s1_valid_q ? s1_rdata_q : s2_rdata_q;
            end

            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    s2_valid_q <= 1'b0;
                    s2_err_q   <= 1'b0;
                    s2_rdata_q <= '0;
                end else begin
                    s2_valid_q <= s2_valid_d;
                    s2_err_q   <= s2_err_d;
                    s2_rdata_q <= s2_rdata_d;
                end
            end

            assign rsp_valid = s2_valid_q;
            assign rsp_err   = s2_err_q;
            assign rsp_rdata = s2_rdata_q;
        end else begin : g_lat1
            assign rsp_valid = s1_valid_q;
            assign rsp_err   = s1_err_q;
            assign rsp_rdata = s1_rdata_q;
        end
    endgenerate

endmodule
`default_nettype wire

// File: tb/tb_data_memory_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_data_memory_ctrl                                          |
// | Description : Self-checking bench for data_memory_ctrl. Instance A uses     |
// |               DEPTH=16, RD_LAT=2 with the clear sequence; instance B uses  |
// |               DEPTH=16, RD_LAT=1 without it. A queue/array reference model |
// |               predicts readiness, busy and every response.                 |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_data_memory_ctrl;

    localparam int DEPTH = 16;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic [1:0]       rst;
    logic [1:0]       req_valid, req_ready, req_write;
    logic [1:0][31:0] req_addr, req_wdata;
    logic [1:0][3:0]  req_be;
    logic [1:0]       rsp_valid, rsp_err, busy;
    logic [1:0][31:0] rsp_rdata;

    data_memory_ctrl #(
        .DATA_W(32), .DEPTH(DEPTH), .ADDR_W(32), .RD_LAT(2), .CLEAR_ON_RESET(1)
    ) u_dut_a (
        .clk(clk), .reset(rst[0]),
        .req_valid(req_valid[0]), .req_ready(req_ready[0]), .req_write(req_write[0]),
        .req_addr(req_addr[0]), .req_wdata(req_wdata[0]), .req_be(req_be[0]),
        .rsp_valid(rsp_valid[0]), .rsp_rdata(rsp_rdata[0]), .rsp_err(rsp_err[0]),
        .busy(busy[0])
    );

    data_memory_ctrl #(
        .DATA_W(32), .DEPTH(DEPTH), .ADDR_W(32), .RD_LAT(1), .CLEAR_ON_RESET(0)
    ) u_dut_b (
        .clk(clk), .reset(rst[1]),
        .req_valid(req_valid[1]), .req_ready(req_ready[1]), .req_write(req_write[1]),
        .req_addr(req_addr[1]), .req_wdata(req_wdata[1]), .req_be(req_be[1]),
        .rsp_valid(rsp_valid[1]), .rsp_rdata(rsp_rdata[1]), .rsp_err(rsp_err[1]),
        .busy(busy[1])
    );

    // ---------------------------------------------------------- reference
    typedef struct {
        int          dut;
        int          due;
        logic        err;
        logic [31:0] data;
    } rsp_t;

    rsp_t        exp_q[$];
    logic [31:0] ref_mem   [2][DEPTH];
    int          since     [2];
    logic [31:0] last_data [2];
    logic        last_err  [2];
    int          cyc    = 0;
    int          n_chk  = 0;
    int          n_fail = 0;

    function automatic int lat_of(input int d);
        return (d == 0) ? 2 : 1;
    endfunction

    function automatic int clr_of(input int d);
        return (d == 0) ? DEPTH : 0;
    endfunction

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s @cyc %0d: got %h, expected %h", tag, cyc, got, exp);
        end
    endtask

    task automatic model_accept(input int d);
        logic [31:0] a;
        int          idx;
        rsp_t        r;
        a      = req_addr[d];
        idx    = int'(a / 4) % DEPTH;
        r.dut  = d;
        r.due  = cyc + lat_of(d) - 1;
        r.err  = ((a % 4) != 0) || (a >= 32'(4 * DEPTH));
        r.data = '0;
        if (!r.err) begin
            if (req_write[d]) begin
                for (int b = 0; b < 4; b++) begin
                    if (req_be[d][b]) ref_mem[d][idx][8*b +: 8] = req_wdata[d][8*b +: 8];
                end
            end else begin
                r.data = ref_mem[d][idx];
            end
        end
        exp_q.push_back(r);
    endtask

    task automatic model_edge();
        cyc++;
        for (int d = 0; d < 2; d++) begin
            if (!rst[d]) begin
                if (req_valid[d] && since[d] >= clr_of(d)) model_accept(d);
                since[d]++;
            end
        end
    endtask

    task automatic check_all();
        for (int d = 0; d < 2; d++) begin
            string n;
            int    hit;
            logic  exp_v;
            n = (d == 0) ? "A" : "B";
            check_eq({n, ".ready"}, 32'(req_ready[d]), 32'(!rst[d] && since[d] >= clr_of(d)));
            check_eq({n, ".busy"}, 32'(busy[d]),
                     32'(rst[d] ? (clr_of(d) > 0) : (since[d] < clr_of(d))));
            hit = -1;
            foreach (exp_q[i]) begin
                if (hit < 0 && exp_q[i].dut == d) hit = i;
            end
            exp_v = (hit >= 0) && (exp_q[hit].due == cyc);
            check_eq({n, ".rsp_valid"}, 32'(rsp_valid[d]), 32'(exp_v));
            if (exp_v) begin
                last_data[d] = exp_q[hit].data;
                last_err[d]  = exp_q[hit].err;
                exp_q.delete(hit);
            end
            check_eq({n, ".rsp_rdata"}, rsp_rdata[d], last_data[d]);
            check_eq({n, ".rsp_err"}, 32'(rsp_err[d]), 32'(last_err[d]));
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        check_all();
    endtask

    task automatic drive(input int d, input logic v, input logic w, input logic [31:0] a,
                         input logic [31:0] wd, input logic [3:0] be);
        req_valid[d] = v;
        req_write[d] = w;
        req_addr[d]  = a;
        req_wdata[d] = wd;
        req_be[d]    = be;
    endtask

    task automatic idle(input int d);
        drive(d, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    endtask

    task automatic do_reset(input int d, input logic on);
        rst[d] = on;
        if (on) begin
            for (int i = exp_q.size() - 1; i >= 0; i--) begin
                if (exp_q[i].dut == d) exp_q.delete(i);
            end
            since[d]     = 0;
            last_data[d] = '0;
            last_err[d]  = 1'b0;
            if (clr_of(d) > 0) begin
                for (int k = 0; k < DEPTH; k++) ref_mem[d][k] = '0;
            end
        end
    endtask

    // ----------------------------------------------------------- stimulus
    initial begin
        idle(0);
        idle(1);
        do_reset(0, 1'b1);
        do_reset(1, 1'b1);
        repeat (3) step();
        do_reset(0, 1'b0);
        do_reset(1, 1'b0);

        // A is clearing: its loads must be ignored. B round-trips 0x04.
        drive(0, 1'b1, 1'b0, 32'h3C, 32'h0, 4'h0);
        drive(1, 1'b1, 1'b1, 32'h04, 32'hCAFEF00D, 4'hF);
        step();
        drive(1, 1'b1, 1'b0, 32'h04, 32'h0, 4'h0);
        step();
        check_eq("B.roundtrip_valid", 32'(rsp_valid[1]), 32'd1);
        check_eq("B.roundtrip_data", rsp_rdata[1], 32'hCAFEF00D);
        idle(0);

        // Byte-lane merge on B.
        drive(1, 1'b1, 1'b1, 32'h10, 32'hDEADBEEF, 4'hF);
        step();
        drive(1, 1'b1, 1'b1, 32'h10, 32'h000000AA, 4'h1);
        step();
        drive(1, 1'b1, 1'b0, 32'h10, 32'h0, 4'h0);
        step();
        check_eq("B.merge_data", rsp_rdata[1], 32'hDEADBEAA);

        // Fill B so random loads never see uninitialised words.
        for (int k = 0; k < DEPTH; k++) begin
            drive(1, 1'b1, 1'b1, 32'(k * 4), $urandom, 4'hF);
            step();
        end
        idle(1);
        step();
        check_eq("A.clear_done", 32'(busy[0]), 32'd0);

        // Cleared word reads zero.
        drive(0, 1'b1, 1'b0, 32'h3C, 32'h0, 4'h0);
        step();
        idle(0);
        step();
        check_eq("A.clear_valid", 32'(rsp_valid[0]), 32'd1);
        check_eq("A.clear_data", rsp_rdata[0], 32'h0);

        // Store then load back-to-back with RD_LAT=2.
        drive(0, 1'b1, 1'b1, 32'h08, 32'h12345678, 4'hF);
        step();
        drive(0, 1'b1, 1'b0, 32'h08, 32'h0, 4'h0);
        step();
        idle(0);
        step();
        check_eq("A.b2b_valid", 32'(rsp_valid[0]), 32'd1);
        check_eq("A.b2b_data", rsp_rdata[0], 32'h12345678);

        // Error responses, then an untouched word.
        drive(0, 1'b1, 1'b0, 32'h06, 32'h0, 4'h0);
        step();
        drive(0, 1'b1, 1'b0, 32'h40, 32'h0, 4'h0);
        step();
        check_eq("A.misalign_err", 32'(rsp_err[0]), 32'd1);
        check_eq("A.misalign_data", rsp_rdata[0], 32'h0);
        drive(0, 1'b1, 1'b0, 32'h00, 32'h0, 4'h0);
        step();
        check_eq("A.oor_err", 32'(rsp_err[0]), 32'd1);
        idle(0);
        step();
        check_eq("A.after_err_err", 32'(rsp_err[0]), 32'd0);
        check_eq("A.after_err_data", rsp_rdata[0], 32'h0);

        // Randomised traffic on both instances.
        for (int it = 0; it < 1500; it++) begin
            for (int d = 0; d < 2; d++) begin
                logic [31:0] a;
                int          sel;
                sel = $urandom_range(0, 7);
                a   = 32'($urandom_range(0, DEPTH - 1)) << 2;
                if (sel == 0) a = a | 32'($urandom_range(1, 3));
                if (sel == 1) a = $urandom | 32'h40;
                drive(d, $urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)), a,
                      $urandom, 4'($urandom));
            end
            step();
        end
        idle(0);
        idle(1);
        repeat (3) step();

        // Reset A with two loads in flight.
        drive(0, 1'b1, 1'b1, 32'h10, 32'hABCD0123, 4'hF);
        step();
        drive(0, 1'b1, 1'b0, 32'h10, 32'h0, 4'h0);
        step();
        drive(0, 1'b1, 1'b0, 32'h14, 32'h0, 4'h0);
        @(posedge clk);
        model_edge();
        #1;
        do_reset(0, 1'b1);
        idle(0);
        @(negedge clk);
        check_all();
        check_eq("A.rst_drop", 32'(rsp_valid[0]), 32'd0);
        repeat (2) step();
        do_reset(0, 1'b0);
        repeat (DEPTH) step();
        check_eq("A.reclear_done", 32'(busy[0]), 32'd0);
        drive(0, 1'b1, 1'b0, 32'h10, 32'h0, 4'h0);
        step();
        idle(0);
        step();
        check_eq("A.reclear_valid", 32'(rsp_valid[0]), 32'd1);
        check_eq("A.reclear_data", rsp_rdata[0], 32'h0);
        repeat (3) step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
